apb_uart_echo_master: RTL and testbench

APB_UART_ECHO_MASTER -- requirements
Module: apb_uart_echo_master

---
 rtl/apb_uart_echo_master.sv | 129 ++++++++++++
 tb/tb_apb_uart_echo_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_echo_master.sv
// APB master that polls a UART status register, pops one received byte and
// writes it back to the transmit register, counting successful echoes.
module apb_uart_echo_master #(
  parameter logic [31:0] ADDR_STATUS = 32'h08,
  parameter logic [31:0] ADDR_RXDATA = 32'h04,
  parameter logic [31:0] ADDR_TXDATA = 32'h00,
  parameter int unsigned POLL_GAP    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic [31:0] out_paddr,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        in_pready,
  input  logic        in_pslverr,
  input  logic [31:0] in_prdata,
  output logic [15:0] echo_count,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GAP, POLL, READ, WRITE} state_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t      state, state_next;
  logic        access, access_next;
  logic [7:0]  gap_cnt;
  logic [7:0]  rx_byte;
  logic [15:0] count;
  logic        err_q;
  logic        in_xfer;
  logic        done;
  logic        rx_ok;
  logic        unused_prdata;

  assign in_xfer       = (state == POLL) || (state == READ) || (state == WRITE);
  assign done          = in_xfer && access && in_pready;
  assign rx_ok         = in_prdata[0] && !in_prdata[1];
  assign unused_prdata = ^in_prdata[31:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      access <= 1'b0;
    end else begin
      state  <= state_next;
      access <= access_next;
    end
  end

  // Each transfer state spends one SETUP cycle (access=0) then ACCESS until pready.
  always_comb begin
    state_next  = state;
    access_next = access;
    case (state)
      IDLE: begin
        access_next = 1'b0;
        if (enable) state_next = GAP;
      end
      GAP: begin
        access_next = 1'b0;
        if (!enable)                  state_next = IDLE;
        else if (gap_cnt == GAP_LAST) state_next = POLL;
      end
      POLL, READ, WRITE: begin
        if (!access) begin
          access_next = 1'b1;
        end else if (in_pready) begin
          access_next = 1'b0;
          if (in_pslverr) begin
            state_next = enable ? GAP : IDLE;
          end else if (state == POLL) begin
            if (!enable)    state_next = IDLE;
            else if (rx_ok) state_next = READ;
            else            state_next = GAP;
          end else if (state == READ) begin
            // a popped byte is always written back, even if enable has dropped
            state_next = WRITE;
          end else begin
            state_next = enable ? GAP : IDLE;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        access_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_cnt   <= '0;
      rx_byte   <= '0;
      count     <= '0;
      err_q     <= 1'b0;
      out_paddr <= '0;
    end else begin
      if ((state == GAP) && (state_next == GAP)) gap_cnt <= gap_cnt + 8'd1;
      else                                      gap_cnt <= '0;

      if (done && (state == READ) && !in_pslverr) rx_byte <= in_prdata[7:0];
      if (done && in_pslverr)                     err_q   <= 1'b1;
      if (done && (state == WRITE) && !in_pslverr) count  <= count + 16'd1;

      // address is loaded for the upcoming transfer and then held afterwards
      if (state_next == POLL)       out_paddr <= ADDR_STATUS;
      else if (state_next == READ)  out_paddr <= ADDR_RXDATA;
      else if (state_next == WRITE) out_paddr <= ADDR_TXDATA;
    end
  end

  assign out_psel    = in_xfer;
  assign out_penable = in_xfer && access;
  assign out_pprot   = '0;
  assign out_pwrite  = (state == WRITE);
  assign out_pwdata  = (state == WRITE) ? {24'h0, rx_byte} : '0;
  assign out_pstrb   = (state == WRITE) ? 4'b0001 : '0;
  assign echo_count  = count;
  assign err         = err_q;
  assign busy        = out_psel;

endmodule

// File: tb/tb_apb_uart_echo_master.sv
// Bench for apb_uart_echo_master: a queue-based UART slave model answers the
// APB bus, and directed/randomized echo sequences are checked against it.
module tb_apb_uart_echo_master;

  localparam int GAP = 5;
  localparam logic [31:0] A_ST = 32'h08;
  localparam logic [31:0] A_RX = 32'h04;
  localparam logic [31:0] A_TX = 32'h00;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        psel, penable, pwrite, err, busy;
  logic [2:0]  pprot;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [15:0] echo_count;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  always #5 clk = ~clk;

  apb_uart_echo_master #(
    .ADDR_STATUS(A_ST),
    .ADDR_RXDATA(A_RX),
    .ADDR_TXDATA(A_TX),
    .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .out_psel(psel), .out_penable(penable), .out_pprot(pprot),
    .out_paddr(paddr), .out_pwrite(pwrite), .out_pwdata(pwdata),
    .out_pstrb(pstrb), .in_pready(pready), .in_pslverr(pslverr),
    .in_prdata(prdata), .echo_count(echo_count), .err(err), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          setup_cyc;
    int          done_cyc;
    int          pen;
    logic        err;
  } xfer_t;

  xfer_t      obs[$];
  xfer_t      cur;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       tx_full = 1'b0;
  logic       inj_rx_err = 1'b0;
  logic       rand_wait = 1'b0;
  logic       in_xfer = 1'b0;
  int         wait_cfg = 0;
  int         wait_left = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // UART slave model and protocol monitor
  always @(negedge clk) begin
    check("pprot", 32'(pprot), 32'd0);
    check("busy_eq_psel", 32'(busy), 32'(psel));
    if (!resetn) begin
      in_xfer = 1'b0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end else if (!psel) begin
      check("idle_penable", 32'(penable), 32'd0);
      check("idle_pwrite", 32'(pwrite), 32'd0);
      check("idle_pwdata", pwdata, 32'd0);
      check("idle_pstrb", 32'(pstrb), 32'd0);
      check("idle_no_open_xfer", 32'(in_xfer), 32'd0);
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end else if (!penable) begin
      check("setup_not_in_xfer", 32'(in_xfer), 32'd0);
      cur.addr      = paddr;
      cur.wr        = pwrite;
      cur.wdata     = pwdata;
      cur.strb      = pstrb;
      cur.setup_cyc = cyc;
      cur.pen       = 0;
      cur.err       = 1'b0;
      in_xfer       = 1'b1;
      wait_left     = rand_wait ? int'($urandom_range(3, 0)) : wait_cfg;
      pready        = 1'b0;
      prdata        = $urandom;
      pslverr       = 1'($urandom);
    end else begin
      check("access_after_setup", 32'(in_xfer), 32'd1);
      check("stable_paddr", paddr, cur.addr);
      check("stable_pwrite", 32'(pwrite), 32'(cur.wr));
      check("stable_pwdata", pwdata, cur.wdata);
      check("stable_pstrb", 32'(pstrb), 32'(cur.strb));
      cur.pen++;
      if (wait_left > 0) begin
        wait_left--;
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end else begin
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = $urandom;
        if (!cur.wr && cur.addr == A_ST) begin
          prdata[0] = (rx_q.size() != 0);
          prdata[1] = tx_full;
        end else if (!cur.wr && cur.addr == A_RX) begin
          if (inj_rx_err) begin
            pslverr    = 1'b1;
            inj_rx_err = 1'b0;
          end else if (rx_q.size() != 0) begin
            prdata[7:0] = rx_q.pop_front();
          end
        end else if (cur.wr && cur.addr == A_TX) begin
          tx_q.push_back(pwdata[7:0]);
        end
        cur.err      = pslverr;
        cur.done_cyc = cyc;
        obs.push_back(cur);
        in_xfer = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 6000) begin
      tick();
      t++;
    end
    check("wait_tx_bound", 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs.size() < n && t < 3000) begin
      tick();
      t++;
    end
    check("wait_obs_bound", 32'(obs.size() >= n), 32'd1);
  endtask

  task automatic wait_access(input logic [31:0] a);
    int t = 0;
    while (!(psel && penable && paddr == a) && t < 3000) begin
      tick();
      t++;
    end
    check("wait_access_bound", 32'(psel && penable && paddr == a), 32'd1);
  endtask

  initial begin
    int c0;
    int n0;
    int idx;
    int ri;
    logic [7:0] b;
    logic [7:0] ref_q[$];

    // reset state
    repeat (3) tick();
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_count", 32'(echo_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // zero-wait echo of 0xA5
    rx_q.push_back(8'hA5);
    c0 = cyc;
    enable = 1'b1;
    wait_tx(1);
    tick();
    check("first_setup_not_early", 32'((obs[0].setup_cyc - c0) >= GAP + 1), 32'd1);
    check("zw_poll_addr", obs[0].addr, A_ST);
    check("zw_poll_rd", 32'(obs[0].wr), 32'd0);
    check("zw_read_addr", obs[1].addr, A_RX);
    check("zw_read_rd", 32'(obs[1].wr), 32'd0);
    check("zw_read_b2b", 32'(obs[1].setup_cyc), 32'(obs[0].done_cyc + 1));
    check("zw_write_addr", obs[2].addr, A_TX);
    check("zw_write_wr", 32'(obs[2].wr), 32'd1);
    check("zw_write_data", obs[2].wdata, 32'h0000_00A5);
    check("zw_write_strb", 32'(obs[2].strb), 32'h1);
    check("zw_write_b2b", 32'(obs[2].setup_cyc), 32'(obs[1].done_cyc + 1));
    check("zw_tx_byte", 32'(tx_q[0]), 32'hA5);
    check("zw_count", 32'(echo_count), 32'd1);

    // three wait states on every access
    wait_cfg = 3;
    repeat (20) tick();
    n0 = obs.size();
    b = 8'($urandom);
    rx_q.push_back(b);
    wait_tx(2);
    tick();
    ri = -1;
    for (int i = n0; i < obs.size(); i++)
      if (obs[i].addr == A_RX && ri < 0) ri = i;
    check("ws_read_found", 32'(ri >= 1), 32'd1);
    if (ri >= 1 && ri + 1 < obs.size()) begin
      check("ws_poll_pen", 32'(obs[ri-1].pen), 32'd4);
      check("ws_read_pen", 32'(obs[ri].pen), 32'd4);
      check("ws_write_pen", 32'(obs[ri+1].pen), 32'd4);
      check("ws_write_data", obs[ri+1].wdata, {24'h0, b});
    end
    check("ws_tx_byte", 32'(tx_q[1]), 32'(b));
    check("ws_count", 32'(echo_count), 32'd2);

    // no data: only status polls, spaced by the gap
    wait_cfg = 0;
    n0 = obs.size();
    wait_obs(n0 + 4);
    for (int k = 0; k < 4; k++)
      check("nodata_addr", obs[n0+k].addr, A_ST);
    for (int k = 1; k < 4; k++)
      check("nodata_gap", 32'(obs[n0+k].setup_cyc - obs[n0+k-1].done_cyc - 1), 32'(GAP));

    // tx full: data waiting but no RXDATA read
    tx_full = 1'b1;
    b = 8'($urandom);
    rx_q.push_back(b);
    n0 = obs.size();
    wait_obs(n0 + 4);
    for (int k = 0; k < 4; k++)
      check("txfull_addr", obs[n0+k].addr, A_ST);
    tx_full = 1'b0;
    wait_tx(3);
    tick();
    check("txfull_tx_byte", 32'(tx_q[2]), 32'(b));
    check("txfull_count", 32'(echo_count), 32'd3);

    // slave error on RXDATA read
    inj_rx_err = 1'b1;
    b = 8'($urandom);
    rx_q.push_back(b);
    begin
      int t = 0;
      while (inj_rx_err && t < 3000) begin
        tick();
        t++;
      end
    end
    idx = obs.size() - 1;
    check("slverr_injected", 32'(inj_rx_err), 32'd0);
    check("slverr_on_read", obs[idx].addr, A_RX);
    tick();
    check("slverr_err", 32'(err), 32'd1);
    check("slverr_count", 32'(echo_count), 32'd3);
    wait_obs(idx + 2);
    check("slverr_next_is_poll", obs[idx+1].addr, A_ST);
    check("slverr_gap", 32'(obs[idx+1].setup_cyc - obs[idx].done_cyc - 1), 32'(GAP));
    wait_tx(4);
    tick();
    check("slverr_retry_byte", 32'(tx_q[3]), 32'(b));
    check("slverr_retry_count", 32'(echo_count), 32'd4);
    check("slverr_sticky", 32'(err), 32'd1);

    // randomized bytes and wait states
    rand_wait = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      ref_q.push_back(b);
      rx_q.push_back(b);
    end
    wait_tx(16);
    tick();
    rand_wait = 1'b0;
    for (int i = 0; i < 12; i++)
      check("rand_tx_byte", 32'(tx_q[4+i]), 32'(ref_q[i]));
    check("rand_count", 32'(echo_count), 32'd16);

    // enable dropped during READ access
    wait_cfg = 2;
    b = 8'($urandom);
    rx_q.push_back(b);
    wait_access(A_RX);
    enable = 1'b0;
    wait_tx(17);
    tick();
    check("endrop_count", 32'(echo_count), 32'd17);
    check("endrop_tx_byte", 32'(tx_q[16]), 32'(b));
    repeat (3 * GAP) tick();
    n0 = obs.size();
    check("endrop_last_write", obs[n0-1].addr, A_TX);
    check("endrop_psel", 32'(psel), 32'd0);
    repeat (3 * GAP) tick();
    check("endrop_stays_idle", 32'(obs.size()), 32'(n0));

    // reset pulsed during WRITE access
    enable = 1'b1;
    wait_cfg = 3;
    b = 8'($urandom);
    rx_q.push_back(b);
    wait_access(A_TX);
    resetn = 1'b0;
    #1;
    check("rstmid_psel", 32'(psel), 32'd0);
    check("rstmid_penable", 32'(penable), 32'd0);
    check("rstmid_count", 32'(echo_count), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    tick();
    tick();
    wait_cfg = 0;
    n0 = obs.size();
    c0 = cyc;
    resetn = 1'b1;
    wait_obs(n0 + 1);
    check("rstmid_no_resume", obs[n0].addr, A_ST);
    check("rstmid_first_setup", 32'((obs[n0].setup_cyc - c0) >= GAP + 1), 32'd1);
    check("rstmid_tx_size", 32'(tx_q.size()), 32'd17);

    // echo_count wrap
    enable = 1'b0;
    repeat (20) tick();
    force dut.count = 16'hFFFF;
    tick();
    release dut.count;
    tick();
    check("wrap_preload", 32'(echo_count), 32'hFFFF);
    enable = 1'b1;
    b = 8'($urandom);
    rx_q.push_back(b);
    wait_tx(18);
    tick();
    check("wrap_count", 32'(echo_count), 32'd0);
    check("wrap_tx_byte", 32'(tx_q[17]), 32'(b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
